// File: rtl/cle_param.sv
// Two-pass connected-component labeller. It makes raster forward and backward
// passes over a label SRAM until no label changes or MAX_PASS iterations have run.
module cle_param #(
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int LABEL_W  = 8,
  parameter int MAX_PASS = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   conn8,
  output logic [X_W+Y_W-4:0]     rom_a,
  input  logic [7:0]             rom_q,
  output logic [X_W+Y_W-1:0]     sram_a,
  input  logic [LABEL_W-1:0]     sram_q,
  output logic [LABEL_W-1:0]     sram_d,
  output logic                   sram_wen,
  output logic                   busy,
  output logic                   finish,
  output logic [3:0]             pass_cnt,
  output logic                   overflow,
  output logic                   timeout
);
  localparam int AW = X_W + Y_W;
  localparam logic [LABEL_W-1:0] LMAX = '1;

  typedef enum logic [3:0] {
    IDLE, FWD_RD, FWD_LAB, FWD_WR, BWD_RD, BWD_LAB, BWD_WR, CHECK, DONE
  } state_t;

  state_t                      state_q;
  logic [AW-1:0]               pix_q;
  logic [2:0]                  rd_k_q;
  logic [4:0][LABEL_W-1:0]     rd_q;     // [0] = self, [4:1] = neighbour slots
  logic                        bit_q, conn8_q, first_q, chg_q;
  logic [LABEL_W:0]            nxt_q;    // MSB set means the label space is used up
  logic [AW-4:0]               rom_a_q;
  logic [AW-1:0]               sram_a_q;
  logic [LABEL_W-1:0]          sram_d_q;
  logic                        wen_q, busy_q, finish_q, ovf_q, to_q;
  logic [3:0]                  pass_q;

  assign rom_a    = rom_a_q;
  assign sram_a   = sram_a_q;
  assign sram_d   = sram_d_q;
  assign sram_wen = wen_q;
  assign busy     = busy_q;
  assign finish   = finish_q;
  assign pass_cnt = pass_q;
  assign overflow = ovf_q;
  assign timeout  = to_q;

  logic                fwd, first_fwd;
  logic [X_W-1:0]      px, xs;
  logic [Y_W-1:0]      py, ys, yo;
  logic [2:0]          bsel;
  logic                xe, yse, yoe;
  logic [4:0][AW-1:0]  slot_a;
  logic [4:1]          nv;
  logic [AW-1:0]       pix_inc, pix_dec;

  assign fwd       = (state_q == FWD_RD) || (state_q == FWD_LAB) || (state_q == FWD_WR);
  assign first_fwd = fwd && first_q;
  assign px        = pix_q[AW-1:Y_W];
  assign py        = pix_q[Y_W-1:0];
  assign bsel      = ~py[2:0];
  assign pix_inc   = pix_q + AW'(1);
  assign pix_dec   = pix_q - AW'(1);

  // Neighbour slots are mirrored between passes: s is -1 forward, +1 backward.
  // Slot 1 = (s,0), 2 = (0,s), 3 = (s,s), 4 = (s,-s); slots 3/4 only when 8-connected.
  always_comb begin
    xs  = fwd ? px - X_W'(1) : px + X_W'(1);
    ys  = fwd ? py - Y_W'(1) : py + Y_W'(1);
    yo  = fwd ? py + Y_W'(1) : py - Y_W'(1);
    xe  = fwd ? (px == '0) : (px == '1);
    yse = fwd ? (py == '0) : (py == '1);
    yoe = fwd ? (py == '1) : (py == '0);
    slot_a[0] = pix_q;
    slot_a[1] = {xs, py};
    slot_a[2] = {px, ys};
    slot_a[3] = {xs, ys};
    slot_a[4] = {xs, yo};
    nv[1] = !xe;
    nv[2] = !yse;
    nv[3] = !xe && !yse && conn8_q;
    nv[4] = !xe && !yoe && conn8_q;
  end

  logic [LABEL_W-1:0] nmax, lbl;
  logic               alloc, chg_set;

  always_comb begin
    nmax = '0;
    for (int k = 1; k < 5; k++)
      if (nv[k] && rd_q[k] > nmax) nmax = rd_q[k];
    lbl   = '0;
    alloc = 1'b0;
    if (first_fwd) begin
      if (bit_q) begin
        if (nmax != '0) lbl = nmax;
        else begin
          alloc = 1'b1;
          lbl   = nxt_q[LABEL_W] ? LMAX : nxt_q[LABEL_W-1:0];
        end
      end
    end else if (rd_q[0] != '0) begin
      lbl = (nmax > rd_q[0]) ? nmax : rd_q[0];
    end
    chg_set = !first_fwd && (lbl != rd_q[0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pix_q    <= '0;
      rd_k_q   <= '0;
      rd_q     <= '0;
      bit_q    <= 1'b0;
      conn8_q  <= 1'b0;
      first_q  <= 1'b0;
      chg_q    <= 1'b0;
      nxt_q    <= '0;
      rom_a_q  <= '0;
      sram_a_q <= '0;
      sram_d_q <= '0;
      wen_q    <= 1'b1;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      pass_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          pass_q   <= '0;
          ovf_q    <= 1'b0;
          to_q     <= 1'b0;
          finish_q <= 1'b0;
          busy_q   <= 1'b1;
          nxt_q    <= (LABEL_W+1)'(1);
          conn8_q  <= conn8;
          first_q  <= 1'b1;
          chg_q    <= 1'b0;
          pix_q    <= '0;
          sram_a_q <= '0;
          rom_a_q  <= '0;
          rd_k_q   <= 3'd1;
          state_q  <= FWD_RD;
        end
        // Reads are pipelined: address issued at step k returns at step k+2.
        FWD_RD, BWD_RD: begin
          if (rd_k_q < 3'd5) sram_a_q <= slot_a[rd_k_q];
          if (rd_k_q >= 3'd2) rd_q[rd_k_q - 3'd2] <= sram_q;
          if (rd_k_q == 3'd2) bit_q <= rom_q[bsel];
          if (rd_k_q == 3'd6) state_q <= fwd ? FWD_LAB : BWD_LAB;
          else rd_k_q <= rd_k_q + 3'd1;
        end
        FWD_LAB, BWD_LAB: begin
          sram_a_q <= pix_q;
          sram_d_q <= lbl;
          wen_q    <= 1'b0;
          if (chg_set) chg_q <= 1'b1;
          if (alloc) begin
            if (nxt_q[LABEL_W]) ovf_q <= 1'b1;
            else nxt_q <= nxt_q + (LABEL_W+1)'(1);
          end
          state_q <= fwd ? FWD_WR : BWD_WR;
        end
        FWD_WR, BWD_WR: begin
          wen_q  <= 1'b1;
          rd_k_q <= 3'd1;
          if (fwd) begin
            if (&pix_q) begin
              sram_a_q <= pix_q;
              state_q  <= BWD_RD;
            end else begin
              pix_q    <= pix_inc;
              sram_a_q <= pix_inc;
              rom_a_q  <= pix_inc[AW-1:3];
              state_q  <= FWD_RD;
            end
          end else begin
            if (pix_q == '0) state_q <= CHECK;
            else begin
              pix_q    <= pix_dec;
              sram_a_q <= pix_dec;
              rom_a_q  <= pix_dec[AW-1:3];
              state_q  <= BWD_RD;
            end
          end
        end
        CHECK: begin
          pass_q <= pass_q + 4'd1;
          if (!chg_q || (pass_q + 4'd1 == 4'(MAX_PASS))) begin
            to_q     <= chg_q;
            finish_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            first_q  <= 1'b0;
            chg_q    <= 1'b0;
            pix_q    <= '0;
            sram_a_q <= '0;
            rom_a_q  <= '0;
            rd_k_q   <= 3'd1;
            state_q  <= FWD_RD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cle_param.sv
// Directed bench: an 8x8 labeller (4-bit labels) and a 32x32 labeller with a single pass limit,
// each with its own ROM and SRAM model.
module tb_cle_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // 8x8, LABEL_W=4, MAX_PASS=15
  logic       d0_start = 1'b0, d0_c8 = 1'b0;
  logic [2:0] d0_rom_a;
  logic [7:0] d0_rom_q;
  logic [5:0] d0_sa;
  logic [3:0] d0_sq, d0_sd, d0_pc;
  logic       d0_wen, d0_busy, d0_fin, d0_ovf, d0_to;
  logic [7:0] rom0 [0:7];
  logic [3:0] sram0 [0:63];
  logic       fill0 = 1'b0;
  int         wr0;

  cle_param #(.X_W(3), .Y_W(3), .LABEL_W(4), .MAX_PASS(15)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(d0_start), .conn8(d0_c8),
    .rom_a(d0_rom_a), .rom_q(d0_rom_q), .sram_a(d0_sa), .sram_q(d0_sq),
    .sram_d(d0_sd), .sram_wen(d0_wen), .busy(d0_busy), .finish(d0_fin),
    .pass_cnt(d0_pc), .overflow(d0_ovf), .timeout(d0_to));

  always @(posedge clk) begin
    d0_rom_q <= rom0[d0_rom_a];
    d0_sq    <= sram0[d0_sa];
    if (fill0) begin
      for (int i = 0; i < 64; i++) sram0[i] <= 4'hA;
      wr0 <= 0;
    end else if (!d0_wen) begin
      sram0[d0_sa] <= d0_sd;
      wr0 <= wr0 + 1;
    end
  end

  // 32x32, LABEL_W=8, MAX_PASS=1
  logic       d1_start = 1'b0, d1_c8 = 1'b0;
  logic [6:0] d1_rom_a;
  logic [7:0] d1_rom_q;
  logic [9:0] d1_sa;
  logic [7:0] d1_sq, d1_sd;
  logic [3:0] d1_pc;
  logic       d1_wen, d1_busy, d1_fin, d1_ovf, d1_to;
  logic [7:0] rom1 [0:127];
  logic [7:0] sram1 [0:1023];
  logic       fill1 = 1'b0;
  int         wr1;

  cle_param #(.X_W(5), .Y_W(5), .LABEL_W(8), .MAX_PASS(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(d1_start), .conn8(d1_c8),
    .rom_a(d1_rom_a), .rom_q(d1_rom_q), .sram_a(d1_sa), .sram_q(d1_sq),
    .sram_d(d1_sd), .sram_wen(d1_wen), .busy(d1_busy), .finish(d1_fin),
    .pass_cnt(d1_pc), .overflow(d1_ovf), .timeout(d1_to));

  always @(posedge clk) begin
    d1_rom_q <= rom1[d1_rom_a];
    d1_sq    <= sram1[d1_sa];
    if (fill1) begin
      for (int i = 0; i < 1024; i++) sram1[i] <= 8'hA5;
      wr1 <= 0;
    end else if (!d1_wen) begin
      sram1[d1_sa] <= d1_sd;
      wr1 <= wr1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scrub SRAM, start with conn8=c8, then flip conn8 (must be ignored); optionally re-pulse start mid-run.
  task automatic run0(input logic c8, input logic poke);
    int n;
    @(negedge clk) fill0 = 1'b1;
    @(negedge clk) begin fill0 = 1'b0; d0_start = 1'b1; d0_c8 = c8; end
    @(negedge clk) begin d0_start = 1'b0; d0_c8 = ~c8; end
    check("d0_busy_run", d0_busy, 1);
    n = 0;
    while (!d0_fin && n < 5000) begin
      @(negedge clk);
      n++;
      d0_start = poke && (n == 100);
    end
    d0_start = 1'b0;
    check("d0_finish", d0_fin, 1);
    check("d0_busy_done", d0_busy, 0);
  endtask

  task automatic run1(input logic c8);
    int n;
    @(negedge clk) fill1 = 1'b1;
    @(negedge clk) begin fill1 = 1'b0; d1_start = 1'b1; d1_c8 = c8; end
    @(negedge clk) d1_start = 1'b0;
    check("d1_busy_run", d1_busy, 1);
    n = 0;
    while (!d1_fin && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("d1_finish", d1_fin, 1);
  endtask

  initial begin
    int nz, n, wsnap;
    for (int i = 0; i < 8; i++) rom0[i] = 8'h00;
    for (int i = 0; i < 128; i++) rom1[i] = 8'h00;

    #23;
    check("d0_reset", {d0_rom_a, d0_sa, d0_sd, d0_wen, d0_busy, d0_fin, d0_pc, d0_ovf, d0_to}, 32'h100);
    check("d1_reset", {d1_sa, d1_sd, d1_wen, d1_busy, d1_fin, d1_pc, d1_ovf, d1_to}, 32'h100);
    check("d1_reset_rom_a", d1_rom_a, 0);
    rst_n = 1'b1;

    // single pixel at (0,0)
    rom0[0] = 8'h80;
    run0(1'b0, 1'b0);
    check("single_pass", d0_pc, 1);
    check("single_lbl", sram0[0], 1);
    nz = 0;
    for (int i = 0; i < 64; i++) if (sram0[i] != 4'h0) nz++;
    check("single_nonzero", nz, 1);
    check("single_writes", wr0, 128);
    check("single_flags", {d0_ovf, d0_to}, 0);

    // (0,0) and (1,1): separate when 4-connected, merged when 8-connected
    rom0[1] = 8'h40;
    run0(1'b0, 1'b0);
    check("diag4_a", sram0[0], 1);
    check("diag4_b", sram0[9], 2);
    run0(1'b1, 1'b0);
    check("diag8_a", sram0[0], 1);
    check("diag8_b", sram0[9], 1);
    check("diag8_pass", d0_pc, 1);

    // U-shape: arms at columns 1 and 5, rows 0..4, joined along row 4
    for (int i = 0; i < 4; i++) rom0[i] = 8'h44;
    rom0[4] = 8'h7C;
    run0(1'b0, 1'b1);
    check("u_pass", d0_pc, 2);
    check("u_writes", wr0, 256);
    check("u_left_top", sram0[1], 2);
    check("u_right_top", sram0[5], 2);
    check("u_bottom_left", sram0[33], 2);
    check("u_bottom_mid", sram0[35], 2);
    check("u_hole", sram0[19], 0);
    check("u_flags", {d0_ovf, d0_to}, 0);

    // reset during the second forward pass
    @(negedge clk) fill0 = 1'b1;
    @(negedge clk) begin fill0 = 1'b0; d0_start = 1'b1; d0_c8 = 1'b0; end
    @(negedge clk) d0_start = 1'b0;
    n = 0;
    while (d0_pc != 4'd1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_pass2", d0_pc, 1);
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort_reset", {d0_rom_a, d0_sa, d0_sd, d0_wen, d0_busy, d0_fin, d0_pc, d0_ovf, d0_to}, 32'h100);
    wsnap = wr0;
    repeat (5) @(negedge clk);
    check("abort_no_writes", wr0, wsnap);
    check("abort_idle_busy", d0_busy, 0);
    #2 rst_n = 1'b1;

    // 4-connected checkerboard exhausts 4-bit labels
    for (int i = 0; i < 8; i++) rom0[i] = i[0] ? 8'h55 : 8'hAA;
    run0(1'b0, 1'b0);
    check("chk_overflow", d0_ovf, 1);
    check("chk_timeout", d0_to, 0);
    check("chk_pass", d0_pc, 1);
    check("chk_first", sram0[0], 1);
    check("chk_row2", sram0[22], 12);
    check("chk_row3", sram0[29], 15);
    check("chk_sat", sram0[63], 15);

    // 32x32 all-zero image
    run1(1'b0);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (sram1[i] != 8'h00) nz++;
    check("zero_nonzero", nz, 0);
    check("zero_pass", d1_pc, 1);
    check("zero_flags", {d1_ovf, d1_to}, 0);
    check("zero_writes", wr1, 2048);

    // spiral needing a second iteration; single-pass limit forces timeout
    rom1[0]  = 8'hF8;
    rom1[4]  = 8'h08;
    rom1[8]  = 8'hB8;
    rom1[12] = 8'h88;
    rom1[16] = 8'hF8;
    run1(1'b0);
    check("spiral_timeout", d1_to, 1);
    check("spiral_pass", d1_pc, 1);
    check("spiral_origin", sram1[0], 3);
    check("spiral_inner", sram1[66], 3);
    check("spiral_ovf", d1_ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/cle_param.md
CLE_PARAM -- requirements
Module: cle_param

Parameters
REQ-001 The block SHALL take parameter X_W, default 5, meaning log2 of the number of image rows (x = row, 0 at top).
REQ-002 The block SHALL take parameter Y_W, default 5, meaning log2 of the number of image columns (y = column, 0 at left); Y_W >= 3.
REQ-003 The block SHALL take parameter LABEL_W, default 8, meaning the label width, equal to the SRAM data width.
REQ-004 The block SHALL take parameter MAX_PASS, default 15, meaning the maximum number of forward+backward iterations, 1..15.

Interface
REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port start, input, 1 bit: a one-cycle pulse that begins labelling; ignored while busy.
REQ-008 Port conn8, input, 1 bit: connectivity (0 = 4-connected, 1 = 8-connected), sampled on an accepted start.
REQ-009 Port rom_a, output, X_W+Y_W-3 bits: binary-image byte address {x, y[Y_W-1:3]}.
REQ-010 Port rom_q, input, 8 bits: 8 pixels, MSB = lowest y; valid one cycle after rom_a.
REQ-011 Port sram_a, output, X_W+Y_W bits: label address {x, y}.
REQ-012 Port sram_q, input, LABEL_W bits: read data, valid one cycle after sram_a with sram_wen=1.
REQ-013 Port sram_d, output, LABEL_W bits: write data.
REQ-014 Port sram_wen, output, 1 bit: active-low write enable.
REQ-015 Port busy, output, 1 bit: high from the cycle after an accepted start until finish rises.
REQ-016 Port finish, output, 1 bit: held high once labelling ends, until the next accepted start.
REQ-017 Port pass_cnt, output, 4 bits: number of completed iterations.
REQ-018 Port overflow, output, 1 bit: sticky, set when label allocation saturates.
REQ-019 Port timeout, output, 1 bit: set when the block stops at MAX_PASS without converging.

Function
REQ-020 The block SHALL have these states: IDLE, FWD_RD, FWD_LAB, FWD_WR, BWD_RD, BWD_LAB, BWD_WR, CHECK, DONE.
REQ-021 From IDLE or DONE, an accepted start SHALL clear pass_cnt, overflow, timeout and finish, set the next-label counter to 1, and enter the forward pass at (0,0).
REQ-022 The forward pass SHALL visit pixels in raster order from (0,0) to (2^X_W-1, 2^Y_W-1).
REQ-023 The backward pass SHALL visit pixels in exact reverse order.
REQ-024 Each pass SHALL assert sram_wen=0 for exactly one cycle per pixel, with sram_a equal to that pixel's address.
REQ-025 Forward-pass neighbours SHALL be up and left; with conn8=1 they SHALL also include up-left and up-right.
REQ-026 Backward-pass neighbours SHALL be down and right; with conn8=1 they SHALL also include down-right and down-left.
REQ-027 Any neighbour outside the image SHALL read as 0, with no wrap between rows or columns.
REQ-028 First forward pass, ROM bit 0: the block SHALL write 0.
REQ-029 First forward pass, ROM bit 1 and some neighbour non-zero: the block SHALL write the maximum neighbour label.
REQ-030 First forward pass, ROM bit 1 and all neighbours zero: the block SHALL write the next label and then increment it.
REQ-031 The next-label counter SHALL saturate at 2^LABEL_W-1; allocating at saturation SHALL set overflow and reuse 2^LABEL_W-1.
REQ-032 In later forward passes and in all backward passes, a pixel reading 0 SHALL be written 0.
REQ-033 In those same passes, a non-zero pixel SHALL be written max(self, non-zero neighbours).
REQ-034 A change flag SHALL be cleared at the start of each iteration.
REQ-035 The change flag SHALL be set by any write in a backward pass or a non-first forward pass whose value differs from the value read.
REQ-036 CHECK SHALL follow the write at (0,0) in each backward pass and SHALL increment pass_cnt.
REQ-037 In CHECK, a clear change flag SHALL cause entry to DONE.
REQ-038 In CHECK, pass_cnt = MAX_PASS SHALL cause timeout to be set and entry to DONE.
REQ-039 In all other CHECK cases, the block SHALL begin another forward pass.
REQ-040 finish SHALL rise on the first cycle in DONE.
REQ-041 start and conn8 changes SHALL be ignored while busy.

Reset
REQ-042 While reset=0, the block SHALL hold: state IDLE, rom_a 0, sram_a 0, sram_d 0, sram_wen 1, busy 0, finish 0, pass_cnt 0, overflow 0, timeout 0.
REQ-043 Reset mid-operation SHALL abort immediately, with no further SRAM writes after reset asserts.
REQ-044 After reset, start SHALL be required to run again; SRAM content left by an aborted run is undefined.

Verification
REQ-045 Scenario: all-zero ROM, 32x32, start -> all SRAM 0, finish=1, pass_cnt=1, timeout=0, overflow=0.
REQ-046 Scenario: single pixel at (0,0) -> SRAM[0]=1, all other entries 0, pass_cnt=1.
REQ-047 Scenario: pixels (0,0) and (1,1) with conn8=0 -> labels 1 and 2; same image with conn8=1 -> both pixels 1.
REQ-048 Scenario: U-shape, two arms joined at the bottom row, conn8=0 -> all U pixels carry the right-arm label (2) after convergence; pass_cnt <= 2.
REQ-049 Scenario: LABEL_W=4, 4-connected checkerboard -> overflow=1, labels saturate at 15, finish=1.
REQ-050 Scenario: reset pulsed mid-way through the second forward pass -> outputs at reset values within 0 cycles; a following start completes correctly; a spiral forcing MAX_PASS=1 -> timeout=1.
